fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the single-cycle core.
- Replaces the combinational instruction-memory lookup with a req/ack memory interface of arbitrary latency.
- Prefetches sequential words into a small queue and presents {instruction, pc} with a valid/ready handshake.
- The core redirects fetch on taken branches and jumps; redirect flushes the queue and squashes any stale in-flight response.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch FSM states, the queue entry layout and a PC alignment helper.
package fetch_pkg;

  localparam int          INSTR_W      = 32;
  localparam int          WORD_OFF     = 2;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:WORD_OFF], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO holding {pc, instr} entries.
// Pointers carry an extra wrap bit so count = wr - rd covers the full range.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_q, wr_d;
  logic [PTR_W:0] rd_q, rd_d;
  entry_t         mem_q [DEPTH];
  logic           empty_s, full_s, do_pop_s, do_push_s;

  assign count     = wr_q - rd_q;
  assign empty_s   = (wr_q == rd_q);
  assign full_s    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && (!full_s || do_pop_s);
  assign head      = mem_q[rd_q[PTR_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push_s) wr_d = wr_q + {{PTR_W{1'b0}}, 1'b1};
      if (do_pop_s)  rd_d = rd_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (do_push_s && !flush) mem_q[wr_q[PTR_W-1:0]] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues single-outstanding req/ack reads, prefetches
// into a small queue and squashes stale responses on core redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr_out,
  output logic [31:0]       instr_pc,
  input  logic              instr_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int                CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_C      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC[ADDR_W+1:WORD_OFF];

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [CNT_W-1:0]  count_s, avail_s, after_push_s;
  logic [31:0]       rpc_s, next_pc_s;
  logic              pop_s, push_s, xfer_s;
  entry_t            head_s, push_entry_s;

  assign xfer_s       = req_q && mem_ack;
  assign pop_s        = (count_s != '0) && instr_ready && !redirect;
  assign avail_s      = count_s - (pop_s ? ONE_C : '0);
  assign after_push_s = avail_s + ONE_C;
  assign rpc_s        = align_pc(redirect_pc);
  assign next_pc_s    = fetch_pc_q + 32'd4;
  assign push_entry_s = '{pc: fetch_pc_q, instr: mem_rdata};

  fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (redirect),
    .head       (head_s),
    .count      (count_s)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push_s     = 1'b0;
    case (state_q)
      IDLE: begin
        // A redirect empties the queue, so it can be fetched immediately.
        if (redirect) begin
          fetch_pc_d = rpc_s;
          req_d      = 1'b1;
          addr_d     = rpc_s[ADDR_W+1:WORD_OFF];
          state_d    = WAIT;
        end else if (avail_s < DEPTH_C) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q[ADDR_W+1:WORD_OFF];
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = rpc_s;
          if (xfer_s) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (xfer_s) begin
          push_s     = 1'b1;
          fetch_pc_d = next_pc_s;
          if (after_push_s < DEPTH_C) begin
            addr_d = next_pc_s[ADDR_W+1:WORD_OFF];
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      DROP: begin
        // The stale request is still held on the bus until it completes.
        if (redirect) fetch_pc_d = rpc_s;
        else          fetch_pc_d = fetch_pc_q;
        if (xfer_s) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  assign instr_valid = (count_s != '0);
  assign instr_out   = instr_valid ? head_s.instr : 32'h0000_0000;
  assign instr_pc    = instr_valid ? head_s.pc    : 32'h0000_0000;
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against an in-order instruction-stream model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, redirect, instr_ready, mem_ack;
  logic [31:0] redirect_pc, mem_rdata, instr_out, instr_pc;
  logic        instr_valid, mem_req;
  logic [5:0]  mem_addr;

  int checks = 0;
  int errors = 0;
  int base_lat = 0;
  bit rand_mode = 1'b0;
  int rand_lat_q = 0;
  int age = 0;

  always #5 clock = ~clock;

  fetch_unit #(.DEPTH(2), .ADDR_W(6), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Memory responder: word k holds 32'h1000_0000 + k, ack after a latency.
  always_comb begin
    mem_ack   = mem_req && (age >= (rand_mode ? rand_lat_q : base_lat));
    mem_rdata = 32'h1000_0000 + {26'd0, mem_addr};
  end

  always @(posedge clock) begin
    if (!mem_req || mem_ack) age <= 0;
    else                     age <= age + 1;
    if (mem_req && mem_ack) rand_lat_q <= int'($urandom_range(0, 3));
  end

  function automatic logic [31:0] ram_word(input logic [31:0] pc);
    return 32'h1000_0000 + {26'd0, pc[7:2]};
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
    rand_mode = 1'b0; base_lat = 0;
    step; step;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040; instr_ready = 1'b1;
    base_lat = 0; rand_mode = 1'b0;
    step; step;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr_out !== 32'd0) begin errors++; $display("FAIL reset_out got %h exp 0", instr_out); end
    checks++; if (instr_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", instr_pc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
    reset = 1'b0; redirect = 1'b0;
    step;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL first_addr got %0d exp 0", mem_addr); end
  endtask

  task automatic test_zero_wait;
    do_reset;
    instr_ready = 1'b1;
    step; step;
    for (int i = 0; i < 12; i++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] got %b exp 1", i, instr_valid); end
      checks++; if (instr_pc !== 32'(i * 4)) begin errors++; $display("FAIL zw_pc[%0d] got %h exp %h", i, instr_pc, 32'(i * 4)); end
      checks++; if (instr_out !== ram_word(32'(i * 4))) begin errors++; $display("FAIL zw_out[%0d] got %h exp %h", i, instr_out, ram_word(32'(i * 4))); end
      step;
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    logic [5:0] a0 = 6'h3F;
    logic [5:0] a1 = 6'h3F;
    do_reset;
    base_lat = 3;
    for (int c = 0; c < 30; c++) begin
      if (mem_req && mem_ack) begin
        if (n == 0) a0 = mem_addr;
        if (n == 1) a1 = mem_addr;
        n++;
      end
      step;
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL bp_nreq got %0d exp 2", n); end
    checks++; if (a0 !== 6'd0 || a1 !== 6'd1) begin errors++; $display("FAIL bp_addrs got %0d,%0d exp 0,1", a0, a1); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_idle got %b exp 0", mem_req); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0) begin errors++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    step;
    instr_ready = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd2) begin errors++; $display("FAIL bp_resume got req=%b addr=%0d exp req=1 addr=2", mem_req, mem_addr); end
  endtask

  task automatic test_redirect_wait;
    do_reset;
    step; step;
    base_lat = 2;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd1) begin errors++; $display("FAIL rw_pre got req=%b addr=%0d exp req=1 addr=1", mem_req, mem_addr); end
    redirect = 1'b1; redirect_pc = 32'h0000_0020;
    step;
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_flush got %b exp 0", instr_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd1) begin errors++; $display("FAIL rw_hold1 got req=%b addr=%0d exp req=1 addr=1", mem_req, mem_addr); end
    step;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd1) begin errors++; $display("FAIL rw_hold2 got req=%b addr=%0d exp req=1 addr=1", mem_req, mem_addr); end
    step;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rw_drop got v=%b req=%b exp v=0 req=0", instr_valid, mem_req); end
    step;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd8) begin errors++; $display("FAIL rw_newreq got req=%b addr=%0d exp req=1 addr=8", mem_req, mem_addr); end
    base_lat = 0;
    step;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr_out !== ram_word(32'h20)) begin errors++; $display("FAIL rw_first got v=%b pc=%h out=%h exp v=1 pc=20 out=%h", instr_valid, instr_pc, instr_out, ram_word(32'h20)); end
  endtask

  task automatic test_redirect_ack;
    logic [31:0] rpc;
    do_reset;
    instr_ready = 1'b1;
    step; step;
    rpc = $urandom;
    redirect = 1'b1; redirect_pc = rpc;
    step;
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL ra_flush got v=%b req=%b exp v=0 req=0", instr_valid, mem_req); end
    step;
    checks++; if (mem_req !== 1'b1 || mem_addr !== rpc[7:2]) begin errors++; $display("FAIL ra_addr got req=%b addr=%0d exp req=1 addr=%0d", mem_req, mem_addr, rpc[7:2]); end
    step;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== {rpc[31:2], 2'b00}) begin errors++; $display("FAIL ra_pc got v=%b pc=%h exp v=1 pc=%h", instr_valid, instr_pc, {rpc[31:2], 2'b00}); end
  endtask

  task automatic test_wrap;
    do_reset;
    repeat (6) step;
    checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL wr_full got req=%b v=%b exp req=0 v=1", mem_req, instr_valid); end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    step;
    redirect = 1'b0; instr_ready = 1'b1;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 6'd63) begin errors++; $display("FAIL wr_req63 got v=%b req=%b addr=%0d exp v=0 req=1 addr=63", instr_valid, mem_req, mem_addr); end
    step;
    checks++; if (instr_pc !== 32'hFFFF_FFFC || instr_out !== 32'h1000_003F || mem_addr !== 6'd0) begin errors++; $display("FAIL wr_top got pc=%h out=%h addr=%0d exp pc=fffffffc out=1000003f addr=0", instr_pc, instr_out, mem_addr); end
    step;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_out !== 32'h1000_0000) begin errors++; $display("FAIL wr_zero got v=%b pc=%h out=%h exp v=1 pc=0 out=10000000", instr_valid, instr_pc, instr_out); end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    base_lat = 5;
    for (int c = 0; c < 20; c++) begin
      if (instr_valid && mem_req) break;
      step;
    end
    checks++; if (instr_valid !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL rm_setup got v=%b req=%b exp v=1 req=1", instr_valid, mem_req); end
    reset = 1'b1;
    step;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || instr_pc !== 32'd0 || instr_out !== 32'd0) begin errors++; $display("FAIL rm_clear got v=%b req=%b pc=%h out=%h exp all 0", instr_valid, mem_req, instr_pc, instr_out); end
    reset = 1'b0;
    step;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 6'd0) begin errors++; $display("FAIL rm_restart got req=%b addr=%0d exp req=1 addr=0", mem_req, mem_addr); end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc = 32'd0;
    logic [5:0]  paddr = 6'd0;
    bit          pend = 1'b0;
    bit          flushed = 1'b0;
    int          delivered = 0;
    do_reset;
    rand_mode = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (flushed) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush[%0d] got %b exp 0", c, instr_valid); end
      end
      if (pend) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== paddr) begin errors++; $display("FAIL rnd_hold[%0d] got req=%b addr=%0d exp req=1 addr=%0d", c, mem_req, mem_addr, paddr); end
      end
      if (instr_valid) begin
        checks++; if (instr_pc !== exp_pc || instr_out !== ram_word(exp_pc)) begin errors++; $display("FAIL rnd_head[%0d] got pc=%h out=%h exp pc=%h out=%h", c, instr_pc, instr_out, exp_pc, ram_word(exp_pc)); end
      end
      pend        = mem_req && !mem_ack;
      paddr       = mem_addr;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      if (redirect) begin
        exp_pc  = {redirect_pc[31:2], 2'b00};
        flushed = 1'b1;
      end else begin
        flushed = 1'b0;
        if (instr_valid && instr_ready) begin
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end
      step;
    end
    redirect = 1'b0;
    checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_throughput got %0d exp >= 200", delivered); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_zero_wait;
    test_backpressure;
    test_redirect_wait;
    test_redirect_ack;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
